// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared PC width, LUT geometry, pc_t, LUT reset defaults and the immediate sign-extend helper
package pc_seq_pkg;
  localparam int PC_W = 12;
  localparam int LUT_IW = 4;
  typedef logic [PC_W-1:0] pc_t;
  localparam pc_t LUT_INIT [2**LUT_IW] = '{
    12'hF97, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
    12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hF7E, 12'h00D, 12'hF88
  };
  function automatic pc_t sext(input logic [LUT_IW-1:0] imm);
    return {{(PC_W-LUT_IW){imm[LUT_IW-1]}}, imm};
  endfunction
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: DEP-entry LIFO (clk_i, rst_i, push_i, pop_i, data_i in; top_o, full_o, empty_o out); push ignored when full, pop ignored when empty
module pc_return_stack #(
  parameter int D = 12,
  parameter int DEP = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [D-1:0] data_i,
  output logic [D-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEP + 1);
  localparam int IW = DEP > 1 ? $clog2(DEP) : 1;
  logic [D-1:0] mem_q [2**IW];
  logic [PW-1:0] ptr_q;
  assign full_o = ptr_q == PW'(DEP);
  assign empty_o = ptr_q == '0;
  assign top_o = mem_q[IW'(ptr_q - PW'(1))];
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[IW'(ptr_q)] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else if (push_i && !full_o) ptr_q <= ptr_q + PW'(1);
    else if (pop_i && !empty_o) ptr_q <= ptr_q - PW'(1);
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with imm/LUT/absolute branch, call/return stack, writable branch LUT; in: Clk Reset stall halt branch_en immOrLUT abs_mode pc_ctrl_input call ret lut_we lut_waddr lut_wdata; out: prog_counter done ras_ovf ras_unf
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D = PC_W,
  parameter int IDX_W = LUT_IW,
  parameter int RAS_DEP = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             immOrLUT,
  input  logic             abs_mode,
  input  logic [IDX_W-1:0] pc_ctrl_input,
  input  logic             call,
  input  logic             ret,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic [D-1:0]     prog_counter,
  output logic             done,
  output logic             ras_ovf,
  output logic             ras_unf
);
  logic [D-1:0] lut_q [2**IDX_W];
  logic [D-1:0] pc_q, pc_d, pc_inc, lut_val, target, top;
  logic done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
  logic active, do_ret, do_call, do_br, full, empty;
  always_comb begin
    lut_val = lut_q[pc_ctrl_input];
    pc_inc = pc_q + D'(1);
    target = !immOrLUT ? pc_q + sext(pc_ctrl_input) : abs_mode ? lut_val : pc_q + lut_val;
    active = !done_q && !stall && !halt;
    do_ret = active && ret;
    do_call = active && !ret && call;
    do_br = active && !ret && (call || branch_en);
    pc_d = !active ? pc_q : do_ret ? (empty ? pc_inc : top) : do_br ? target : pc_inc;
    done_d = done_q || (!done_q && !stall && halt);
    ovf_d = ovf_q || (do_call && full);
    unf_d = unf_q || (do_ret && empty);
  end
  pc_return_stack #(.D(D), .DEP(RAS_DEP)) u_ras (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .push_i (do_call),
    .pop_i  (do_ret),
    .data_i (pc_inc),
    .top_o  (top),
    .full_o (full),
    .empty_o(empty)
  );
  always_ff @(posedge Clk) begin
    if (Reset) lut_q <= LUT_INIT;
    else if (lut_we) lut_q[lut_waddr] <= lut_wdata;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign prog_counter = pc_q;
  assign done = done_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed vectors plus hand sequences for pc_sequencer
module tb_pc_sequencer;
  logic Clk = 1'b0, Reset = 1'b0, stall = 1'b0, halt = 1'b0, branch_en = 1'b0;
  logic immOrLUT = 1'b0, abs_mode = 1'b0, call = 1'b0, ret = 1'b0, lut_we = 1'b0;
  logic [3:0] pc_ctrl_input = '0, lut_waddr = '0;
  logic [11:0] lut_wdata = '0, prog_counter;
  logic done, ras_ovf, ras_unf;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [8:0] c;
    logic [3:0] idx;
    logic [3:0] wa;
    logic [11:0] wd;
    logic [11:0] pc;
    logic [2:0] f;
  } vec_t;
  vec_t vq[$];
  always #5 Clk = ~Clk;
  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .halt(halt), .branch_en(branch_en),
    .immOrLUT(immOrLUT), .abs_mode(abs_mode), .pc_ctrl_input(pc_ctrl_input),
    .call(call), .ret(ret), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_counter(prog_counter), .done(done), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );
  task automatic step(input vec_t v, input string name);
    @(negedge Clk);
    {Reset, stall, halt, branch_en, immOrLUT, abs_mode, call, ret, lut_we} = v.c;
    pc_ctrl_input = v.idx;
    lut_waddr = v.wa;
    lut_wdata = v.wd;
    @(posedge Clk);
    #1;
    n_vec++;
    if (prog_counter !== v.pc || {done, ras_ovf, ras_unf} !== v.f) begin
      n_bad++;
      $display("FAIL %s: pc=%0d flags(done,ovf,unf)=%b, want pc=%0d flags=%b",
               name, prog_counter, {done, ras_ovf, ras_unf}, v.pc, v.f);
    end
  endtask
  initial begin
    // ctrl bits: rst stall halt br iol abs call ret we
    vq.push_back('{9'b100000000, 4'd0, 4'd0, 12'd0, 12'd0, 3'b000});
    for (int i = 1; i <= 5; i++) vq.push_back('{9'b000000000, 4'd0, 4'd0, 12'd0, 12'(i), 3'b000});
    vq.push_back('{9'b000000001, 4'd0, 4'd1, 12'd200, 12'd6, 3'b000});
    vq.push_back('{9'b000111000, 4'd1, 4'd0, 12'd0, 12'd200, 3'b000});
    vq.push_back('{9'b000110000, 4'd0, 4'd0, 12'd0, 12'd95, 3'b000});
    vq.push_back('{9'b000110000, 4'd14, 4'd0, 12'd0, 12'd108, 3'b000});
    vq.push_back('{9'b000000001, 4'd0, 4'd2, 12'd10, 12'd109, 3'b000});
    vq.push_back('{9'b000111000, 4'd2, 4'd0, 12'd0, 12'd10, 3'b000});
    vq.push_back('{9'b000101000, 4'd8, 4'd0, 12'd0, 12'd2, 3'b000});
    vq.push_back('{9'b000000001, 4'd0, 4'd1, 12'd4095, 12'd3, 3'b000});
    vq.push_back('{9'b000111000, 4'd1, 4'd0, 12'd0, 12'd4095, 3'b000});
    vq.push_back('{9'b000000000, 4'd0, 4'd0, 12'd0, 12'd0, 3'b000});
    vq.push_back('{9'b000111001, 4'd3, 4'd3, 12'h123, 12'd0, 3'b000});
    vq.push_back('{9'b000111000, 4'd3, 4'd0, 12'd0, 12'h123, 3'b000});
    vq.push_back('{9'b000110000, 4'd15, 4'd0, 12'd0, 12'h0AB, 3'b000});
    vq.push_back('{9'b010100000, 4'd1, 4'd0, 12'd0, 12'h0AB, 3'b000});
    vq.push_back('{9'b010000100, 4'd1, 4'd0, 12'd0, 12'h0AB, 3'b000});
    vq.push_back('{9'b010000001, 4'd0, 4'd4, 12'd5, 12'h0AB, 3'b000});
    vq.push_back('{9'b000110000, 4'd4, 4'd0, 12'd0, 12'd176, 3'b000});
    for (int i = 177; i <= 180; i++) vq.push_back('{9'b000000100, 4'd1, 4'd0, 12'd0, 12'(i), 3'b000});
    vq.push_back('{9'b000000100, 4'd1, 4'd0, 12'd0, 12'd181, 3'b010});
    for (int i = 180; i >= 177; i--) vq.push_back('{9'b000000010, 4'd0, 4'd0, 12'd0, 12'(i), 3'b010});
    vq.push_back('{9'b000000010, 4'd0, 4'd0, 12'd0, 12'd178, 3'b011});
    vq.push_back('{9'b000000110, 4'd1, 4'd0, 12'd0, 12'd179, 3'b011});
    vq.push_back('{9'b000000010, 4'd0, 4'd0, 12'd0, 12'd180, 3'b011});
    vq.push_back('{9'b000000100, 4'd2, 4'd0, 12'd0, 12'd182, 3'b011});
    vq.push_back('{9'b000100010, 4'd5, 4'd0, 12'd0, 12'd181, 3'b011});
    vq.push_back('{9'b100000000, 4'd0, 4'd0, 12'd0, 12'd0, 3'b000});
    vq.push_back('{9'b000100000, 4'd7, 4'd0, 12'd0, 12'd7, 3'b000});
    vq.push_back('{9'b001000000, 4'd0, 4'd0, 12'd0, 12'd7, 3'b100});
    vq.push_back('{9'b000100000, 4'd1, 4'd0, 12'd0, 12'd7, 3'b100});
    vq.push_back('{9'b000000001, 4'd0, 4'd5, 12'h010, 12'd7, 3'b100});
    vq.push_back('{9'b111100000, 4'd1, 4'd0, 12'd0, 12'd0, 3'b000});
    vq.push_back('{9'b000110000, 4'd5, 4'd0, 12'd0, 12'd0, 3'b000});
    vq.push_back('{9'b000110000, 4'd0, 4'd0, 12'd0, 12'hF97, 3'b000});
    vq.push_back('{9'b000110000, 4'd13, 4'd0, 12'd0, 12'hF15, 3'b000});
    vq.push_back('{9'b000111000, 4'd1, 4'd0, 12'd0, 12'd0, 3'b000});
    foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));
    step('{9'b001000000, 4'd0, 4'd0, 12'd0, 12'd0, 3'b100}, "halt_at0");
    for (int i = 0; i < 3; i++) step('{9'b000000010, 4'd0, 4'd0, 12'd0, 12'd0, 3'b100}, "ret_while_done");
    step('{9'b000000100, 4'd3, 4'd0, 12'd0, 12'd0, 3'b100}, "call_while_done");
    step('{9'b100000000, 4'd0, 4'd0, 12'd0, 12'd0, 3'b000}, "reset_after_done");
    step('{9'b000000010, 4'd0, 4'd0, 12'd0, 12'd1, 3'b001}, "ret_empty_after_reset");
    step('{9'b010000010, 4'd0, 4'd0, 12'd0, 12'd1, 3'b001}, "stall_holds_ret");
    step('{9'b001000010, 4'd0, 4'd0, 12'd0, 12'd1, 3'b101}, "halt_beats_ret");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
